sync_fifo_prog: RTL
===================

// Module: sync_fifo_prog
// PURPOSE
// - Single-clock parametrised FIFO: the synchronous successor to the dual-clock FIFO, for
//   same-domain buffering between VIO-driven stimulus and downstream logic.
// - Adds occupancy count, programmable almost-full/almost-empty, sticky overflow/underflow
//   error flags and an optional first-word-fall-through (FWFT) read mode.
// - Storage is an inferred RAM array with no reset on the data path.
// PARAMETERS
// - WIDTH      10  data word width, bits
// - DEPTH      32  entries; must be a power of 2, >= 4; ADDRW = $clog2(DEPTH)
// - AF_THRESH  28  almost_full asserted when count >= AF_THRESH (1..DEPTH)
// - AE_THRESH  4   almost_empty asserted when count <= AE_THRESH (0..DEPTH-1)
// PORTS
// - clk           in   1          sole clock; all logic is on the rising edge
// - reset_n       in   1          async active-low reset; assert async, deassert sync to clk upstream
// - wr            in   1          write request
// - datain        in   WIDTH      write data, sampled with wr
// - rd            in   1          read request / pop
// - dataout       out  WIDTH      read data
// - valid         out  1          dataout holds a newly popped word (standard mode)
// - clr_err       in   1          single-cycle pulse clears overflow and underflow
// - full          out  1          count == DEPTH
// - empty         out  1          no word available for reading
// - almost_full   out  1          count >= AF_THRESH
// - almost_empty  out  1          count <= AE_THRESH
// - count         out  ADDRW+1    current occupancy, 0..DEPTH
// - overflow      out  1          sticky: wr seen while full
// - underflow     out  1          sticky: rd seen while empty
// BEHAVIOUR
// - Reset (reset_n=0, asynchronous):
//   - wr_ptr = rd_ptr = 0, count = 0, dataout = 0, valid = 0
//   - empty = 1, full = 0, almost_empty = 1, almost_full = 0, overflow = underflow = 0
//   - Reset mid-operation discards all contents; RAM contents need not be cleared.
// - Pointers are ADDRW+1 bits: the MSB is the wrap bit and the low ADDRW bits are the RAM address.
//   - full  = ptr MSBs differ and low bits are equal.
//   - count = wr_ptr - rd_ptr, modulo 2^(ADDRW+1).
// - Accept rules:
//   - wr_acc = wr & ~full; rd_acc = rd & ~empty.
//   - Requests that are not accepted have no effect on data or pointers.
// - Simultaneous wr_acc and rd_acc: both pointers advance and count is unchanged.
// - Full and empty are evaluated before the edge, so when full, wr is rejected even if rd is
//   accepted in the same cycle.
// - Write at count == DEPTH-1: full asserts the next cycle, with count == DEPTH.
// - Pointer wrap: after DEPTH writes the address returns to 0 and the MSB toggles. No special case.
// - Status outputs (full, empty, almost_*, count) are registered.
//   - Each updates on the cycle after the accepting edge (latency 1) and never glitches.
// - Error flags:
//   - overflow  <= 1 on wr & full; underflow <= 1 on rd & empty.
//   - clr_err clears both flags; set has priority over clr_err in the same cycle.
// - Standard mode (macro undefined):
//   - rd_acc at edge N: dataout = mem[rd_ptr] and valid = 1 after edge N (1-cycle read latency).
//   - valid = 0 on any cycle without rd_acc; dataout holds its last value.
//   - empty = (count == 0).
//   - Write into empty: empty deasserts 1 cycle after the write edge; a rd is then accepted.
// - Thresholds are checked by elaboration assertions: DEPTH power of 2, AE_THRESH < AF_THRESH.
// CONFIGURATION
// - SYNC_FIFO_FWFT_EN defined: first-word-fall-through.
//   - dataout = mem[rd_ptr] continuously while ~empty; rd acts as a pop/acknowledge.
//   - valid is tied to ~empty.
//   - Write into empty: dataout shows the word and empty deasserts 1 cycle after the write edge.
//   - Pop of the last word: empty asserts the next cycle.
//   - count, full, almost_* and error flags behave exactly as in standard mode.
// - SYNC_FIFO_FWFT_EN undefined: standard registered-read mode as above.
// TESTING
// Defaults: WIDTH=10, DEPTH=32.
// - T1 reset: drop reset_n mid-burst at count=17.
//   -> all outputs take their reset values asynchronously, before the next clk edge.
// - T2 fill: 32 writes of 0x000..0x01F.
//   -> almost_full rises after the 28th write, full and count=32 after the 32nd.
//   -> 33rd wr sets overflow; count stays 32.
// - T3 drain: 32 reads after T2.
//   -> valid=1 with dataout 0x000..0x01F in order, 1 cycle after each rd.
//   -> empty after the last read; an extra rd sets underflow; clr_err clears both flags.
// - T4 simultaneous: at count=5, assert wr and rd together for 100 cycles with incrementing data.
//   -> count stays 5, with no data loss or reorder across at least 3 pointer wraps.
// - T5 full corner: at full, assert wr and rd together.
//   -> rd accepted, wr rejected and overflow set; count=31 the next cycle.
// - T6 FWFT (SYNC_FIFO_FWFT_EN): single write of 0x2A5 into empty.
//   -> next cycle: empty=0, dataout=0x2A5, valid=1.
//   -> rd pop -> empty=1 the next cycle.

Source files
------------

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with registered occupancy/status, programmable almost-full/almost-empty,
// sticky overflow/underflow flags. Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_prog #(
  parameter int WIDTH     = 10,
  parameter int DEPTH     = 32,
  parameter int AF_THRESH = 28,
  parameter int AE_THRESH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr,
  input  logic [WIDTH-1:0]         datain,
  input  logic                     rd,
  output logic [WIDTH-1:0]         dataout,
  output logic                     valid,
  input  logic                     clr_err,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int ADDRW = $clog2(DEPTH);
  localparam logic [ADDRW:0] AF_CNT = AF_THRESH[ADDRW:0];
  localparam logic [ADDRW:0] AE_CNT = AE_THRESH[ADDRW:0];

  // Parameter sanity, caught at elaboration rather than in silicon.
  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("sync_fifo_prog: DEPTH must be a power of 2 and >= 4");
  end
  if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_bad_af
    $error("sync_fifo_prog: AF_THRESH must be in 1..DEPTH");
  end
  if ((AE_THRESH < 0) || (AE_THRESH >= AF_THRESH)) begin : g_bad_ae
    $error("sync_fifo_prog: AE_THRESH must be >= 0 and < AF_THRESH");
  end

  logic [WIDTH-1:0] mem [DEPTH];

  logic [ADDRW:0] wr_ptr;
  logic [ADDRW:0] rd_ptr;
  logic [ADDRW:0] wr_ptr_nxt;
  logic [ADDRW:0] rd_ptr_nxt;
  logic [ADDRW:0] count_nxt;
  logic           full_nxt;
  logic           empty_nxt;
  logic           wr_acc;
  logic           rd_acc;

  // Accept decisions use the registered flags, i.e. the state before the edge.
  assign wr_acc = wr & ~full;
  assign rd_acc = rd & ~empty;

  always_comb begin
    wr_ptr_nxt = wr_ptr + {{ADDRW{1'b0}}, wr_acc};
    rd_ptr_nxt = rd_ptr + {{ADDRW{1'b0}}, rd_acc};
    count_nxt  = wr_ptr_nxt - rd_ptr_nxt;
    full_nxt   = (wr_ptr_nxt[ADDRW] != rd_ptr_nxt[ADDRW]) &&
                 (wr_ptr_nxt[ADDRW-1:0] == rd_ptr_nxt[ADDRW-1:0]);
    empty_nxt  = (wr_ptr_nxt == rd_ptr_nxt);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      wr_ptr       <= wr_ptr_nxt;
      rd_ptr       <= rd_ptr_nxt;
      count        <= count_nxt;
      full         <= full_nxt;
      empty        <= empty_nxt;
      almost_full  <= (count_nxt >= AF_CNT);
      almost_empty <= (count_nxt <= AE_CNT);
    end
  end

  // Error flags: a new error in the same cycle wins over clr_err.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr && full)   overflow <= 1'b1;
      else if (clr_err) overflow <= 1'b0;
      if (rd && empty)  underflow <= 1'b1;
      else if (clr_err) underflow <= 1'b0;
    end
  end

  // Data path storage carries no reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr[ADDRW-1:0]] <= datain;
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is presented continuously; rd only acknowledges it.
  assign dataout = empty ? '0 : mem[rd_ptr[ADDRW-1:0]];
  assign valid   = ~empty;
`else
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dataout <= '0;
      valid   <= 1'b0;
    end else begin
      valid <= rd_acc;
      if (rd_acc) dataout <= mem[rd_ptr[ADDRW-1:0]];
    end
  end
`endif

endmodule
